// File: rtl/twist_to_delta_pose_pkg.sv
// Shared configuration for the twist-to-delta-pose block: word format,
// Q-format constants, convergence threshold and index enums.
package twist_to_delta_pose_pkg;

  localparam int POSE_BW = 42;
  localparam int MUL     = 24;
  localparam int THRESH  = 16;
  localparam int NUM_XI  = 6;
  localparam int NUM_OUT = 12;

  typedef logic signed [POSE_BW-1:0] pose_word_t;

  localparam pose_word_t ONE = pose_word_t'(64'sd1 <<< MUL);

  // Twist element positions on i_xi
  typedef enum logic [2:0] {W1 = 3'd0, W2, W3, V1, V2, V3} twist_idx_e;

  // Halved second-order terms, listed in the order the multiplier produces them
  typedef enum logic [2:0] {H11 = 3'd0, H22, H33, H12, H13, H23} prod_idx_e;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  // Strictly inside (-THRESH, THRESH); the most-negative code falls outside
  function automatic logic is_small(input pose_word_t x);
    return (x > -pose_word_t'(THRESH)) && (x < pose_word_t'(THRESH));
  endfunction

endpackage

// File: rtl/twist_to_delta_pose_if.sv
// Request/result bundle between the Gauss-Newton solver side and the
// twist-to-delta-pose block.
interface twist_to_delta_pose_if;
  import twist_to_delta_pose_pkg::*;

  logic       i_start;
  pose_word_t i_xi [NUM_XI];
  logic       o_done;
  pose_word_t o_delta_pose [NUM_OUT];
  logic       o_small;

  modport master (
    output i_start,
    output i_xi,
    input  o_done,
    input  o_delta_pose,
    input  o_small
  );

  modport slave (
    input  i_start,
    input  i_xi,
    output o_done,
    output o_delta_pose,
    output o_small
  );

endinterface

// File: rtl/pose_mul_pipe.sv
// Two-stage signed DATA_W x DATA_W multiplier with an arithmetic post-shift
// (truncation toward -inf) applied to the full-width product before it is
// narrowed back to DATA_W bits.
module pose_mul_pipe #(
  parameter int DATA_W = 42,
  parameter int SHIFT  = 25
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vld,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic                     res_vld,
  output logic signed [DATA_W-1:0] res
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [DATA_W-1:0] a_p0;
  logic signed [DATA_W-1:0] b_p0;
  logic                     vld_p0;
  logic signed [PROD_W-1:0] prod_p0;
  logic signed [DATA_W-1:0] res_p1;
  logic                     vld_p1;

  function automatic logic signed [DATA_W-1:0] post_shift(input logic signed [PROD_W-1:0] p);
    return DATA_W'(p >>> SHIFT);
  endfunction

  // Stage 0: operand registers
  always_ff @(posedge clk) begin
    a_p0 <= a;
    b_p0 <= b;
  end

  // Valid travels with the data through both stages
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= vld;
      vld_p1 <= vld_p0;
    end
  end

  // Full-width signed product of the stage-0 operands
  always_comb begin
    prod_p0 = PROD_W'(a_p0) * PROD_W'(b_p0);
  end

  // Stage 1: shifted, narrowed product
  always_ff @(posedge clk) begin
    res_p1 <= post_shift(prod_p0);
  end

  assign res     = res_p1;
  assign res_vld = vld_p1;

endmodule

// File: rtl/twist_to_delta_pose.sv
// Converts a 6-DoF twist increment (w1,w2,w3,v1,v2,v3) into a row-major 3x4
// delta pose [R|t] using a second-order exponential-map approximation, and
// flags convergence when every twist element is below THRESH in magnitude.
// Build option: TWIST_ORDER2_EN enables the second-order terms (shared
// pipelined multiplier, done 10 cycles after start); without it the block is
// first-order only (diagonals = ONE, done 2 cycles after start).
module twist_to_delta_pose
  import twist_to_delta_pose_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  twist_to_delta_pose_if.slave bus
);

`ifdef TWIST_ORDER2_EN
  // Six issues plus two cycles of multiplier latency drain by count 8
  localparam logic [3:0] LAST_CNT = 4'd8;
`else
  localparam logic [3:0] LAST_CNT = 4'd0;
`endif

  state_e     state;
  state_e     state_nxt;
  logic [3:0] cnt;
  logic       latch_xi;
  logic       run;
  logic       finish;
  logic       small_nxt;
  pose_word_t xi_q      [NUM_XI];
  pose_word_t h         [NUM_XI];
  pose_word_t delta_nxt [NUM_OUT];

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a start outside IDLE is simply not looked at
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.i_start) state_nxt = CALC;
      CALC:    if (cnt == LAST_CNT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded control strobes
  always_comb begin
    latch_xi = (state == IDLE) && bus.i_start;
    run      = (state == CALC);
    finish   = (state == DONE);
  end

  // CALC counter and twist capture on the accepted start
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt  <= 4'd0;
      xi_q <= '{default: '0};
    end else begin
      cnt <= run ? cnt + 4'd1 : 4'd0;
      if (latch_xi) xi_q <= bus.i_xi;
    end
  end

`ifdef TWIST_ORDER2_EN
  logic       mul_vld;
  logic       res_vld;
  pose_word_t op_a;
  pose_word_t op_b;
  pose_word_t res;

  // Operand select: one product per CALC cycle for counts 0..5
  always_comb begin
    mul_vld = run && (cnt < 4'd6);
    op_a    = '0;
    op_b    = '0;
    case (cnt)
      4'd0:    begin op_a = xi_q[W1]; op_b = xi_q[W1]; end
      4'd1:    begin op_a = xi_q[W2]; op_b = xi_q[W2]; end
      4'd2:    begin op_a = xi_q[W3]; op_b = xi_q[W3]; end
      4'd3:    begin op_a = xi_q[W1]; op_b = xi_q[W2]; end
      4'd4:    begin op_a = xi_q[W1]; op_b = xi_q[W3]; end
      4'd5:    begin op_a = xi_q[W2]; op_b = xi_q[W3]; end
      default: ;
    endcase
  end

  // The extra shift bit halves each product
  pose_mul_pipe #(
    .DATA_W (POSE_BW),
    .SHIFT  (MUL + 1)
  ) u_mul (
    .clk     (i_clk),
    .rst     (i_rst),
    .vld     (mul_vld),
    .a       (op_a),
    .b       (op_b),
    .res_vld (res_vld),
    .res     (res)
  );

  // Halved-term capture: the product issued at count c appears at count c+2
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h <= '{default: '0};
    end else if (run && res_vld) begin
      case (cnt)
        4'd2:    h[H11] <= res;
        4'd3:    h[H22] <= res;
        4'd4:    h[H33] <= res;
        4'd5:    h[H12] <= res;
        4'd6:    h[H13] <= res;
        4'd7:    h[H23] <= res;
        default: ;
      endcase
    end
  end
`else
  // First-order build: every second-order term is zero
  always_comb begin
    h = '{default: '0};
  end
`endif

  // [R|t] assembly with wrapping POSE_BW arithmetic, plus convergence flag
  always_comb begin
    delta_nxt[0]  = ONE - h[H22] - h[H33];
    delta_nxt[1]  = -xi_q[W3] + h[H12];
    delta_nxt[2]  =  xi_q[W2] + h[H13];
    delta_nxt[3]  =  xi_q[V1];
    delta_nxt[4]  =  xi_q[W3] + h[H12];
    delta_nxt[5]  = ONE - h[H11] - h[H33];
    delta_nxt[6]  = -xi_q[W1] + h[H23];
    delta_nxt[7]  =  xi_q[V2];
    delta_nxt[8]  = -xi_q[W2] + h[H13];
    delta_nxt[9]  =  xi_q[W1] + h[H23];
    delta_nxt[10] = ONE - h[H11] - h[H22];
    delta_nxt[11] =  xi_q[V3];
    small_nxt = 1'b1;
    for (int k = 0; k < NUM_XI; k++) begin
      small_nxt = small_nxt && is_small(xi_q[k]);
    end
  end

  // Result registers load on the edge that raises o_done, then hold
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_done       <= 1'b0;
      bus.o_small      <= 1'b0;
      bus.o_delta_pose <= '{default: '0};
    end else begin
      bus.o_done <= finish;
      if (finish) begin
        bus.o_delta_pose <= delta_nxt;
        bus.o_small      <= small_nxt;
      end
    end
  end

endmodule

// File: tb/tb_twist_to_delta_pose.sv
// Self-checking bench for twist_to_delta_pose; follows TWIST_ORDER2_EN for
// the expected latency and second-order terms.
module tb_twist_to_delta_pose;
  import twist_to_delta_pose_pkg::*;

`ifdef TWIST_ORDER2_EN
  localparam bit ORDER2    = 1'b1;
  localparam int LAT       = 10;
  localparam int SECOND_AT = 4;
  localparam int RST_AT    = 5;
`else
  localparam bit ORDER2    = 1'b0;
  localparam int LAT       = 2;
  localparam int SECOND_AT = 1;
  localparam int RST_AT    = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  twist_to_delta_pose_if bus();

  twist_to_delta_pose dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // floor((a*b) / 2^(MUL+1)) using plain integer division
  function automatic longint half_term(input longint a, input longint b);
    longint p = a * b;
    longint d = 64'sd1 <<< (MUL + 1);
    longint q = p / d;
    if ((p % d != 0) && (p < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void model(input longint x[6], output longint e[12], output bit s);
    longint one = 64'sd1 <<< MUL;
    longint h11 = ORDER2 ? half_term(x[0], x[0]) : 64'sd0;
    longint h22 = ORDER2 ? half_term(x[1], x[1]) : 64'sd0;
    longint h33 = ORDER2 ? half_term(x[2], x[2]) : 64'sd0;
    longint h12 = ORDER2 ? half_term(x[0], x[1]) : 64'sd0;
    longint h13 = ORDER2 ? half_term(x[0], x[2]) : 64'sd0;
    longint h23 = ORDER2 ? half_term(x[1], x[2]) : 64'sd0;
    e[0]  = one - h22 - h33;  e[1] = -x[2] + h12;  e[2]  =  x[1] + h13;  e[3]  = x[3];
    e[4]  = x[2] + h12;       e[5] = one - h11 - h33; e[6] = -x[0] + h23; e[7] = x[4];
    e[8]  = -x[1] + h13;      e[9] = x[0] + h23;   e[10] = one - h11 - h22; e[11] = x[5];
    s = 1'b1;
    for (int k = 0; k < 6; k++) begin
      longint m = (x[k] < 0) ? -x[k] : x[k];
      if (m >= THRESH) s = 1'b0;
    end
  endfunction

  function automatic longint rand_w();
    return longint'($urandom_range(32'h7fff_ffff, 0)) - 64'sd1073741824;
  endfunction

  function automatic longint rand_v();
    pose_word_t t;
    t = pose_word_t'({$urandom(), $urandom()});
    return longint'(t);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic start_req(input longint x[6]);
    @(negedge clk);
    bus.i_start = 1'b1;
    for (int k = 0; k < 6; k++) bus.i_xi[k] = pose_word_t'(x[k]);
    @(posedge clk);
    #1 bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk);
      #1;
      if (bus.o_done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
    n_checks++;
    if (bus.o_small !== 1'b0) begin n_fail++; $display("FAIL reset_small: got %b want 0", bus.o_small); end
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (bus.o_delta_pose[i] !== '0) begin
        n_fail++; $display("FAIL reset_pose[%0d]: got %0d want 0", i, bus.o_delta_pose[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    longint tbl[7][6];
    bit     sm_e[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int     sv[8]   = '{1, 1, 1, 1, 1, 2, 2, 2};
    int     si[8]   = '{0, 1, 4, 3, 11, 0, 2, 10};
`ifdef TWIST_ORDER2_EN
    longint se[8]   = '{16776378, -167772, 167772, 16777216, -8388608, 8388608, -16777216, 0};
`else
    longint se[8]   = '{16777216, -167772, 167772, 16777216, -8388608, 16777216, -16777216, 16777216};
`endif
    longint e[12];
    bit     s;
    int     lat;
    tbl = '{'{0, 0, 0, 0, 0, 0},
            '{0, 0, 167772, 16777216, 0, -8388608},
            '{-16777216, -16777216, 0, 0, 0, 0},
            '{15, -15, 15, -15, 15, -15},
            '{15, 15, 16, 0, 0, 0},
            '{0, 0, 0, 0, -16, 0},
            '{0, 0, 0, -64'sd2199023255552, 0, 0}};
    for (int v = 0; v < 7; v++) begin
      model(tbl[v], e, s);
      start_req(tbl[v]);
      wait_done(40, lat);
      n_checks++;
      if (lat !== LAT) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", v, lat, LAT); end
      for (int i = 0; i < 12; i++) begin
        n_checks++;
        if (bus.o_delta_pose[i] !== pose_word_t'(e[i])) begin
          n_fail++; $display("FAIL dir%0d_pose[%0d]: got %0d want %0d", v, i, bus.o_delta_pose[i], e[i]);
        end
      end
      n_checks++;
      if (bus.o_small !== sm_e[v]) begin n_fail++; $display("FAIL dir%0d_small: got %b want %b", v, bus.o_small, sm_e[v]); end
      for (int j = 0; j < 8; j++) begin
        if (sv[j] == v) begin
          n_checks++;
          if (bus.o_delta_pose[si[j]] !== pose_word_t'(se[j])) begin
            n_fail++; $display("FAIL dir%0d_const[%0d]: got %0d want %0d", v, si[j], bus.o_delta_pose[si[j]], se[j]);
          end
        end
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_width: got %b want 0", v, bus.o_done); end
    end
  endtask

  task automatic test_ignored_start;
    longint x1[6] = '{1000, -2000, 3000, 4, 5, 6};
    longint x2[6] = '{-777777, 888888, 999999, 7, 8, 9};
    longint e[12];
    bit     s;
    int     lat;
    int     dones = 0;
    model(x1, e, s);
    start_req(x1);
    repeat (SECOND_AT - 1) @(posedge clk);
    start_req(x2);
    wait_done(40, lat);
    n_checks++;
    if (lat !== LAT - SECOND_AT) begin
      n_fail++; $display("FAIL ignore_latency: got %0d want %0d", lat, LAT - SECOND_AT);
    end
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (bus.o_delta_pose[i] !== pose_word_t'(e[i])) begin
        n_fail++; $display("FAIL ignore_pose[%0d]: got %0d want %0d", i, bus.o_delta_pose[i], e[i]);
      end
    end
    for (int n = 0; n < 2 * LAT + 4; n++) begin
      @(posedge clk);
      #1;
      if (bus.o_done === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL ignore_extra_done: got %0d want 0", dones); end
  endtask

  task automatic test_reset_mid;
    longint x1[6] = '{123456, -654321, 111111, 42, -42, 7};
    longint x2[6] = '{-5000000, 2500000, 16777216, -1, 2, -3};
    longint e[12];
    bit     s;
    int     lat;
    int     dones = 0;
    start_req(x1);
    repeat (RST_AT - 1) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < LAT + 4; n++) begin
      @(posedge clk);
      #1;
      if (bus.o_done === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL rstmid_done: got %0d want 0", dones); end
    n_checks++;
    if (bus.o_small !== 1'b0) begin n_fail++; $display("FAIL rstmid_small: got %b want 0", bus.o_small); end
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (bus.o_delta_pose[i] !== '0) begin
        n_fail++; $display("FAIL rstmid_pose[%0d]: got %0d want 0", i, bus.o_delta_pose[i]);
      end
    end
    model(x2, e, s);
    start_req(x2);
    wait_done(40, lat);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL rstmid_latency: got %0d want %0d", lat, LAT); end
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (bus.o_delta_pose[i] !== pose_word_t'(e[i])) begin
        n_fail++; $display("FAIL rstmid_pose2[%0d]: got %0d want %0d", i, bus.o_delta_pose[i], e[i]);
      end
    end
  endtask

  task automatic test_random;
    longint x[6];
    longint e[12];
    longint prev[12];
    bit     s;
    bit     prev_s;
    int     lat;
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 6; k++) begin
        if (it % 4 == 3) x[k] = longint'($urandom_range(40, 0)) - 64'sd20;
        else if (k < 3)  x[k] = rand_w();
        else             x[k] = rand_v();
      end
      model(x, e, s);
      start_req(x);
      if (it > 0) begin
        for (int i = 0; i < 12; i++) begin
          n_checks++;
          if (bus.o_delta_pose[i] !== pose_word_t'(prev[i])) begin
            n_fail++; $display("FAIL rand%0d_hold[%0d]: got %0d want %0d", it, i, bus.o_delta_pose[i], prev[i]);
          end
        end
        n_checks++;
        if (bus.o_small !== prev_s) begin n_fail++; $display("FAIL rand%0d_hold_small: got %b want %b", it, bus.o_small, prev_s); end
      end
      wait_done(40, lat);
      n_checks++;
      if (lat !== LAT) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, LAT); end
      for (int i = 0; i < 12; i++) begin
        n_checks++;
        if (bus.o_delta_pose[i] !== pose_word_t'(e[i])) begin
          n_fail++; $display("FAIL rand%0d_pose[%0d]: got %0d want %0d", it, i, bus.o_delta_pose[i], e[i]);
        end
      end
      n_checks++;
      if (bus.o_small !== s) begin n_fail++; $display("FAIL rand%0d_small: got %b want %b", it, bus.o_small, s); end
      prev   = e;
      prev_s = s;
    end
  endtask

  initial begin
    bus.i_start = 1'b0;
    for (int k = 0; k < 6; k++) bus.i_xi[k] = '0;
    test_reset();
    test_directed();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/twist_to_delta_pose.md
Name: twist_to_delta_pose

Overview:
- Upstream neighbour of the pose-update stage: converts the 6-DoF twist increment xi = (w1,w2,w3,v1,v2,v3) from the Gauss-Newton solver into a 3x4 delta-pose matrix [R|t].
- Output is row-major, 12 words, in exactly the element order the pose-update stage's delta inputs expect.
- Uses a second-order exponential-map approximation with one shared pipelined multiplier.
- Also flags solver convergence (small twist).

Parameters:
- POSE_BW, 42, signed word width of twist and pose elements.
- MUL, 24, fraction bits (Q-format); ONE = 1<<MUL = 16777216.
- THRESH, 16, convergence threshold in LSBs, applied to |xi_k|.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle request; samples i_xi
- i_xi  in  POSE_BW x6  signed twist, order w1,w2,w3,v1,v2,v3
- o_done  out  1  one-cycle pulse, outputs valid
- o_delta_pose  out  POSE_BW x12  signed [R00 R01 R02 t0 R10 R11 R12 t1 R20 R21 R22 t2]
- o_small  out  1  all six |xi_k| < THRESH

Behaviour:
- Reset: state IDLE, counter 0, o_done=0, o_small=0, all o_delta_pose=0, internal twist and product registers 0.
- FSM states:
  - IDLE: i_start -> CALC; i_xi latched on that edge.
  - CALC: counter runs; at the final count -> DONE.
  - DONE: o_done=1 for exactly one cycle, then IDLE.
- i_start while not IDLE is ignored (no relatch, no extra done).
- Latency: o_done is high in cycle k+10 when i_start was sampled at edge k (ORDER2_EN). Without ORDER2_EN it is k+2.
- Outputs hold their values until the next completed request. o_delta_pose and o_small update on the same edge that raises o_done.
- Products (ORDER2_EN):
  - Six products issued one per CALC cycle in order w1*w1, w2*w2, w3*w3, w1*w2, w1*w3, w2*w3.
  - Multiplier latency is 2 cycles.
  - Each product P (2*POSE_BW) is reduced to h = P >>> (MUL+1): arithmetic shift, truncation toward -inf, no rounding. This is the halved term.
- Assembly (all sums wrap in POSE_BW two's complement, no saturation):
  - R00 = ONE-h22-h33; R11 = ONE-h11-h33; R22 = ONE-h11-h22
  - R01 = -w3+h12; R10 = w3+h12
  - R02 = w2+h13; R20 = -w2+h13
  - R12 = -w1+h23; R21 = w1+h23
  - t = (v1,v2,v3) unchanged
- o_small:
  - |x| taken in two's complement.
  - The most-negative code is never small.
  - Computed from the latched twist.
- Reset mid-operation: returns to IDLE with reset values; no o_done is produced. The next i_start works normally.

Optional Feature:
- Macro TWIST_ORDER2_EN.
- Defined: second-order terms as above, multiplier instantiated, latency 10.
- Undefined: first-order only (all h terms = 0, so diagonals = ONE), no multiplier instantiated, CALC lasts one cycle, latency 2. Port list is unchanged.

Decomposition:
- RgbdVoConfigPk holds POSE_BW, MUL, the ONE constant, THRESH default, and a twist index enum (W1..V3).
- Natural sub-module: pose_mul_pipe. It is a 2-stage signed POSE_BW x POSE_BW multiplier with selectable post-shift. It is reusable by the pose-update stage.

Test Plan:
- xi all 0 -> o_delta_pose[0],[5],[10]=16777216, all others 0; o_small=1; o_done exactly at k+10.
- w3=167772, v=(16777216,0,-8388608), rest 0:
  - rotation: [0]=[5]=16776378, [10]=16777216, [1]=-167772, [4]=167772
  - translation: [3]=16777216, [7]=0, [11]=-8388608
  - o_small=0
- w1=w2=-16777216, rest 0:
  - [0]=[5]=8388608, [10]=0, [1]=[4]=8388608
  - [2]=-16777216, [8]=16777216, [6]=16777216, [9]=-16777216
- i_start pulsed again at k+4 with different xi -> single o_done at k+10, results from first xi; o_small boundary: xi_k = ±15 gives 1, xi_k = 16 gives 0.
- i_rst at k+5 -> no o_done, outputs 0; a new i_start at k+8 gives correct results at k+18.
- Build without TWIST_ORDER2_EN using the second vector -> [0]=[5]=[10]=16777216, [1]=-167772, [4]=167772; o_done at k+2.
